rr_credit_allocator: RTL and testbench
======================================

Name: rr_credit_allocator

Overview:
- Per-output-port switch allocator for the NoC router; one instance per output channel, identified by OUT_CHAN_ID.
- Arbitrates among IN_N input VCs whose route result targets this output.
- Locks the winner for a whole wormhole packet, head to tail.
- Gates every flit on downstream credits; supports round-robin and hop-count-priority arbitration modes.

Parameters:
- IN_N, 5, number of input channels competing for this output
- OUT_M, 5, number of router outputs; RTR_RES_W = $clog2(OUT_M)
- FLIT_ID_W, 2, flit type field width
- HOP_CNT_W, 4, hop count width per input
- OUT_CHAN_ID, 0, output index this allocator serves
- CREDIT_DEPTH, 4, downstream buffer depth in flits; CNT_W = $clog2(CREDIT_DEPTH+1)
- ARB_MODE, 0, arbitration mode: 0 = round-robin; 1 = highest hop count wins, round-robin tie-break

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- rtr_res_i  in  IN_N*RTR_RES_W  per-input route result (output index)
- rtr_res_vld_i  in  IN_N  per-input route result valid
- hop_count_i  in  IN_N*HOP_CNT_W  per-input hop count of head flit
- flit_id_i  in  IN_N*FLIT_ID_W  per-input flit type at VC head
- data_vld_i  in  IN_N  per-input VC has a flit
- credit_i  in  1  one-cycle pulse; downstream freed one slot
- sel_o  out  $clog2(IN_N)  crossbar select = locked owner
- out_vld_o  out  1  flit transferred this cycle
- chan_alloc_o  out  IN_N  one-hot pop strobe to owner VC
- credit_cnt_o  out  CNT_W  current credit count
- busy_o  out  1  allocator is in LOCKED
- err_o  out  1  sticky flag: credit overflow

Behaviour:
- Flit ID encoding: 00 SINGLE, 01 HEAD, 10 BODY, 11 TAIL.
- Reset values (async, rst_i=1):
  - state = IDLE; owner = 0; rr_ptr = 0; credit count = CREDIT_DEPTH; err_o = 0.
  - out_vld_o, chan_alloc_o and busy_o = 0; sel_o = 0.
  - Reset mid-packet abandons the lock immediately.
- Request: req[i] = data_vld_i[i] & rtr_res_vld_i[i] & (rtr_res_i[i] == OUT_CHAN_ID) & (flit_id_i[i] is HEAD or SINGLE).
- IDLE state:
  - If any req and credit > 0: pick winner, register owner, set rr_ptr = (winner+1) mod IN_N, go to LOCKED next edge.
  - No flit is transferred in IDLE.
  - With credit == 0, stay in IDLE with no grant.
- Arbitration:
  - ARB_MODE 0: first requester at or after rr_ptr, cyclically.
  - ARB_MODE 1: mask requests to those with maximum hop_count_i, then apply round-robin from rr_ptr.
  - Unsigned compare.
- LOCKED state:
  - xfer = data_vld_i[owner] & (credit > 0).
  - Combinationally: out_vld_o = xfer; chan_alloc_o = xfer ? onehot(owner) : 0; sel_o = owner; busy_o = 1.
  - On xfer with flit_id TAIL or SINGLE: return to IDLE next edge.
  - Otherwise hold the lock.
  - If owner's data_vld_i is low, or credit is 0: stall and hold the lock.
  - Other inputs are ignored while locked.
  - Route result is not rechecked for body/tail flits.
- Latency:
  - Request seen at edge t; head flit is forwarded in the cycle after edge t+1.
  - Exactly one IDLE cycle between consecutive packets.
  - Peak throughput: 1 flit/cycle within a packet.
- Credits:
  - Decrement on xfer; increment on credit_i; both in the same cycle leaves the count unchanged.
  - Never transfers at 0 credits, so underflow is impossible.
  - credit_i at CREDIT_DEPTH without a simultaneous xfer: count saturates and err_o is set sticky until reset.
- sel_o holds its last owner value in IDLE.

Decomposition:
- Shared package noc_pkg holds:
  - flit ID localparams FLIT_SINGLE/HEAD/BODY/TAIL;
  - ARB_RR/ARB_HOP mode constants;
  - state encodings ST_IDLE/ST_LOCKED.
- One sub-module: rr_arbiter.
  - Parametrised by N.
  - Inputs: req, ptr. Outputs: one-hot grant and index. Purely combinational.
  - The hop-count max-masking stays in the parent.

Test Plan:
- Reset, then inputs 1 and 3 both send HEAD, BODY, TAIL to OUT_CHAN_ID=0, with CREDIT_DEPTH=4 and credit_i returned each cycle → input 1 wins (rr_ptr=0).
  - Required: sel_o=1, chan_alloc_o=00010 for 3 flits, then 1 IDLE cycle, then sel_o=3, chan_alloc_o=01000 for 3 flits.
- Input 2 sends HEAD with rtr_res=3 while OUT_CHAN_ID=0 → no grant; out_vld_o stays 0.
- 6-flit packet with no credit_i returned → 4 transfers, credit_cnt_o reaches 0, stall with busy_o=1.
  - Then one credit_i pulse → exactly one more flit forwarded.
- ARB_MODE=1: inputs 0, 2, 4 send HEAD with hop counts 3, 7, 7; rr_ptr=3 → input 4 wins, then input 2 on the next packet, then input 0.
- Owner's data_vld_i drops for 3 cycles mid-packet while input 0 requests → lock held, input 0 not granted until after TAIL.
- credit_i pulse at credit_cnt_o=4 with no transfer → count stays 4 and err_o=1.
  - Assert rst_i mid-packet → outputs 0 asynchronously, credit_cnt_o=4, err_o=0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit type codes, arbitration modes and
// allocator state encodings.
package noc_pkg;

  localparam logic [1:0] FLIT_SINGLE = 2'b00;
  localparam logic [1:0] FLIT_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_BODY   = 2'b10;
  localparam logic [1:0] FLIT_TAIL   = 2'b11;

  localparam int ARB_RR  = 0;
  localparam int ARB_HOP = 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } alloc_state_t;

endpackage

// File: rtl/rr_credit_allocator_if.sv
// Per-output allocator bus: input-VC request/flit status towards the
// allocator, crossbar select, pop strobes and credit status back.
interface rr_credit_allocator_if #(
  parameter int IN_N         = 5,
  parameter int OUT_M        = 5,
  parameter int FLIT_ID_W    = 2,
  parameter int HOP_CNT_W    = 4,
  parameter int CREDIT_DEPTH = 4
);
  localparam int RTR_RES_W = $clog2(OUT_M);
  localparam int SEL_W     = $clog2(IN_N);
  localparam int CNT_W     = $clog2(CREDIT_DEPTH + 1);

  logic [IN_N*RTR_RES_W-1:0] rtr_res_i;
  logic [IN_N-1:0]           rtr_res_vld_i;
  logic [IN_N*HOP_CNT_W-1:0] hop_count_i;
  logic [IN_N*FLIT_ID_W-1:0] flit_id_i;
  logic [IN_N-1:0]           data_vld_i;
  logic                      credit_i;
  logic [SEL_W-1:0]          sel_o;
  logic                      out_vld_o;
  logic [IN_N-1:0]           chan_alloc_o;
  logic [CNT_W-1:0]          credit_cnt_o;
  logic                      busy_o;
  logic                      err_o;

  modport master (
    output rtr_res_i, rtr_res_vld_i, hop_count_i, flit_id_i, data_vld_i, credit_i,
    input  sel_o, out_vld_o, chan_alloc_o, credit_cnt_o, busy_o, err_o
  );

  modport slave (
    input  rtr_res_i, rtr_res_vld_i, hop_count_i, flit_id_i, data_vld_i, credit_i,
    output sel_o, out_vld_o, chan_alloc_o, credit_cnt_o, busy_o, err_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or
// after ptr, wrapping cyclically.
module rr_arbiter #(
  parameter  int N     = 5,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    logic [IDX_W-1:0] j;
    int               pos;
    grant = '0;
    idx   = '0;
    j     = '0;
    pos   = 0;
    // Walk from farthest to nearest offset so the nearest requester wins last.
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      j = IDX_W'(pos);
      if (req[j]) begin
        grant = N'(1) << j;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/rr_credit_allocator.sv
// Output-port switch allocator: locks one input VC for a whole wormhole
// packet and forwards flits only while downstream credits are available.
module rr_credit_allocator
  import noc_pkg::*;
#(
  parameter int IN_N         = 5,
  parameter int OUT_M        = 5,
  parameter int FLIT_ID_W    = 2,
  parameter int HOP_CNT_W    = 4,
  parameter int OUT_CHAN_ID  = 0,
  parameter int CREDIT_DEPTH = 4,
  parameter int ARB_MODE     = ARB_RR
) (
  input logic clk_i,
  input logic rst_i,
  rr_credit_allocator_if.slave bus
);

  localparam int RTR_RES_W = $clog2(OUT_M);
  localparam int SEL_W     = $clog2(IN_N);
  localparam int CNT_W     = $clog2(CREDIT_DEPTH + 1);

  alloc_state_t   state, state_nxt;
  logic [SEL_W-1:0] owner, owner_nxt, rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0] credit_cnt, credit_cnt_nxt;
  logic             err, err_nxt;

  logic [IN_N-1:0]      req, req_arb, win_grant;
  logic [SEL_W-1:0]     win_idx;
  logic [HOP_CNT_W-1:0] hop_max;
  logic [FLIT_ID_W-1:0] owner_fid;
  logic                 credit_ok, xfer, last_flit;

  always_comb begin
    req     = '0;
    req_arb = '0;
    hop_max = '0;
    for (int i = 0; i < IN_N; i++) begin
      req[i] = bus.data_vld_i[i] && bus.rtr_res_vld_i[i] &&
               (bus.rtr_res_i[i*RTR_RES_W +: RTR_RES_W] == RTR_RES_W'(OUT_CHAN_ID)) &&
               ((bus.flit_id_i[i*FLIT_ID_W +: FLIT_ID_W] == FLIT_ID_W'(FLIT_HEAD)) ||
                (bus.flit_id_i[i*FLIT_ID_W +: FLIT_ID_W] == FLIT_ID_W'(FLIT_SINGLE)));
      if (req[i] && (bus.hop_count_i[i*HOP_CNT_W +: HOP_CNT_W] > hop_max))
        hop_max = bus.hop_count_i[i*HOP_CNT_W +: HOP_CNT_W];
    end
    // Hop mode narrows the contenders to the farthest-travelled flits first.
    for (int i = 0; i < IN_N; i++)
      req_arb[i] = (ARB_MODE == ARB_HOP)
                 ? req[i] && (bus.hop_count_i[i*HOP_CNT_W +: HOP_CNT_W] == hop_max)
                 : req[i];
  end

  rr_arbiter #(.N(IN_N)) u_arb (
    .req   (req_arb),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx)
  );

  assign owner_fid = bus.flit_id_i[int'(owner)*FLIT_ID_W +: FLIT_ID_W];
  assign credit_ok = (credit_cnt != '0);
  assign last_flit = (owner_fid == FLIT_ID_W'(FLIT_TAIL)) ||
                     (owner_fid == FLIT_ID_W'(FLIT_SINGLE));

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned and infers a latch.
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    xfer       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if ((|req) && credit_ok) begin
          owner_nxt  = win_idx;
          rr_ptr_nxt = (win_idx == SEL_W'(IN_N - 1)) ? '0 : win_idx + 1'b1;
          state_nxt  = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        xfer = bus.data_vld_i[owner] && credit_ok;
        if (xfer && last_flit) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    credit_cnt_nxt = credit_cnt;
    err_nxt        = err;
    if (bus.credit_i && !xfer) begin
      // A return with the buffer already full is a protocol error; saturate.
      if (credit_cnt == CNT_W'(CREDIT_DEPTH)) err_nxt = 1'b1;
      else                                    credit_cnt_nxt = credit_cnt + 1'b1;
    end else if (xfer && !bus.credit_i) begin
      credit_cnt_nxt = credit_cnt - 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      credit_cnt <= CNT_W'(CREDIT_DEPTH);
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      rr_ptr     <= rr_ptr_nxt;
      credit_cnt <= credit_cnt_nxt;
      err        <= err_nxt;
    end
  end

  assign bus.sel_o        = owner;
  assign bus.out_vld_o    = xfer;
  assign bus.chan_alloc_o = xfer ? (IN_N'(1) << owner) : '0;
  assign bus.busy_o       = (state == ST_LOCKED);
  assign bus.credit_cnt_o = credit_cnt;
  assign bus.err_o        = err;

endmodule

// File: tb/tb_rr_credit_allocator.sv
// Directed bench for rr_credit_allocator: one round-robin and one
// hop-priority instance driven cycle by cycle against hand-computed rows.
module tb_rr_credit_allocator;
  import noc_pkg::*;

  localparam logic [1:0] S = FLIT_SINGLE;
  localparam logic [1:0] H = FLIT_HEAD;
  localparam logic [1:0] B = FLIT_BODY;
  localparam logic [1:0] T = FLIT_TAIL;

  // One cycle of stimulus plus the outputs expected in that same cycle.
  typedef struct {
    logic [4:0] vld;
    logic [9:0] fid;
    logic       cr;
    logic       o_vld;
    logic [2:0] o_sel;
    logic [4:0] o_alloc;
    logic       o_busy;
    logic [2:0] o_cnt;
  } row_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rr_credit_allocator_if #(.IN_N(5), .OUT_M(5), .FLIT_ID_W(2), .HOP_CNT_W(4),
                           .CREDIT_DEPTH(4)) bus_rr ();
  rr_credit_allocator_if #(.IN_N(5), .OUT_M(5), .FLIT_ID_W(2), .HOP_CNT_W(4),
                           .CREDIT_DEPTH(4)) bus_hop ();

  rr_credit_allocator #(.IN_N(5), .OUT_M(5), .FLIT_ID_W(2), .HOP_CNT_W(4),
                        .OUT_CHAN_ID(0), .CREDIT_DEPTH(4), .ARB_MODE(ARB_RR))
    dut_rr (.clk_i(clk), .rst_i(rst), .bus(bus_rr.slave));

  rr_credit_allocator #(.IN_N(5), .OUT_M(5), .FLIT_ID_W(2), .HOP_CNT_W(4),
                        .OUT_CHAN_ID(0), .CREDIT_DEPTH(4), .ARB_MODE(ARB_HOP))
    dut_hop (.clk_i(clk), .rst_i(rst), .bus(bus_hop.slave));

  function automatic logic [9:0] fl(input logic [1:0] f0, f1, f2, f3, f4);
    return {f4, f3, f2, f1, f0};
  endfunction

  function automatic row_t mk(input logic [4:0] vld, input logic [9:0] fid, input logic cr,
                              input logic o_vld, input logic [2:0] o_sel,
                              input logic [4:0] o_alloc, input logic o_busy,
                              input logic [2:0] o_cnt);
    row_t r;
    r.vld = vld; r.fid = fid; r.cr = cr; r.o_vld = o_vld; r.o_sel = o_sel;
    r.o_alloc = o_alloc; r.o_busy = o_busy; r.o_cnt = o_cnt;
    return r;
  endfunction

  task automatic apply_rr(input row_t r);
    bus_rr.data_vld_i = r.vld;
    bus_rr.flit_id_i  = r.fid;
    bus_rr.credit_i   = r.cr;
  endtask

  task automatic apply_hop(input row_t r);
    bus_hop.data_vld_i = r.vld;
    bus_hop.flit_id_i  = r.fid;
    bus_hop.credit_i   = r.cr;
  endtask

  task automatic run_rr_rows(input string name, input row_t rows[$]);
    logic [12:0] act, exp;
    for (int k = 0; k < rows.size(); k++) begin
      apply_rr(rows[k]);
      @(negedge clk);
      act = {bus_rr.out_vld_o, bus_rr.sel_o, bus_rr.chan_alloc_o, bus_rr.busy_o, bus_rr.credit_cnt_o};
      exp = {rows[k].o_vld, rows[k].o_sel, rows[k].o_alloc, rows[k].o_busy, rows[k].o_cnt};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s row %0d: {vld,sel,alloc,busy,cnt} got %b_%0d_%b_%b_%0d want %b_%0d_%b_%b_%0d",
                 name, k, act[12], act[11:9], act[8:4], act[3], act[2:0],
                 exp[12], exp[11:9], exp[8:4], exp[3], exp[2:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus_rr.out_vld_o, bus_rr.chan_alloc_o, bus_rr.busy_o, bus_rr.sel_o, bus_rr.err_o} !== 11'b0 ||
        bus_rr.credit_cnt_o !== 3'd4) begin
      errors++;
      $display("FAIL reset_rr: vld=%b alloc=%b busy=%b sel=%0d err=%b cnt=%0d, want zeros and cnt=4",
               bus_rr.out_vld_o, bus_rr.chan_alloc_o, bus_rr.busy_o, bus_rr.sel_o,
               bus_rr.err_o, bus_rr.credit_cnt_o);
    end
    checks++;
    if ({bus_hop.out_vld_o, bus_hop.chan_alloc_o, bus_hop.busy_o, bus_hop.sel_o, bus_hop.err_o} !== 11'b0 ||
        bus_hop.credit_cnt_o !== 3'd4) begin
      errors++;
      $display("FAIL reset_hop: vld=%b alloc=%b busy=%b cnt=%0d, want zeros and cnt=4",
               bus_hop.out_vld_o, bus_hop.chan_alloc_o, bus_hop.busy_o, bus_hop.credit_cnt_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_two_packets();
    row_t rows[$];
    rows.push_back(mk(5'b01010, fl(S, H, S, H, S), 0, 0, 0, 5'b00000, 0, 4));
    rows.push_back(mk(5'b01010, fl(S, H, S, H, S), 1, 1, 1, 5'b00010, 1, 4));
    rows.push_back(mk(5'b01010, fl(S, B, S, H, S), 1, 1, 1, 5'b00010, 1, 4));
    rows.push_back(mk(5'b01010, fl(S, T, S, H, S), 1, 1, 1, 5'b00010, 1, 4));
    rows.push_back(mk(5'b01000, fl(S, S, S, H, S), 0, 0, 1, 5'b00000, 0, 4));
    rows.push_back(mk(5'b01000, fl(S, S, S, H, S), 1, 1, 3, 5'b01000, 1, 4));
    rows.push_back(mk(5'b01000, fl(S, S, S, B, S), 1, 1, 3, 5'b01000, 1, 4));
    rows.push_back(mk(5'b01000, fl(S, S, S, T, S), 1, 1, 3, 5'b01000, 1, 4));
    rows.push_back(mk(5'b00000, fl(S, S, S, S, S), 0, 0, 3, 5'b00000, 0, 4));
    run_rr_rows("two_packets", rows);
  endtask

  task automatic test_route_miss();
    row_t rows[$];
    bus_rr.rtr_res_i[2*3 +: 3] = 3'd3;
    for (int k = 0; k < 3; k++)
      rows.push_back(mk(5'b00100, fl(S, S, H, S, S), 0, 0, 3, 5'b00000, 0, 4));
    run_rr_rows("route_miss", rows);
    bus_rr.rtr_res_i[2*3 +: 3] = 3'd0;
  endtask

  task automatic test_credit_stall();
    row_t rows[$];
    rows.push_back(mk(5'b00001, fl(H, S, S, S, S), 0, 0, 3, 5'b00000, 0, 4));
    rows.push_back(mk(5'b00001, fl(H, S, S, S, S), 0, 1, 0, 5'b00001, 1, 4));
    rows.push_back(mk(5'b00001, fl(B, S, S, S, S), 0, 1, 0, 5'b00001, 1, 3));
    rows.push_back(mk(5'b00001, fl(B, S, S, S, S), 0, 1, 0, 5'b00001, 1, 2));
    rows.push_back(mk(5'b00001, fl(B, S, S, S, S), 0, 1, 0, 5'b00001, 1, 1));
    rows.push_back(mk(5'b00001, fl(B, S, S, S, S), 0, 0, 0, 5'b00000, 1, 0));
    rows.push_back(mk(5'b00001, fl(B, S, S, S, S), 0, 0, 0, 5'b00000, 1, 0));
    rows.push_back(mk(5'b00001, fl(B, S, S, S, S), 1, 0, 0, 5'b00000, 1, 0));
    rows.push_back(mk(5'b00001, fl(B, S, S, S, S), 0, 1, 0, 5'b00001, 1, 1));
    rows.push_back(mk(5'b00001, fl(T, S, S, S, S), 0, 0, 0, 5'b00000, 1, 0));
    rows.push_back(mk(5'b00001, fl(T, S, S, S, S), 1, 0, 0, 5'b00000, 1, 0));
    rows.push_back(mk(5'b00001, fl(T, S, S, S, S), 0, 1, 0, 5'b00001, 1, 1));
    rows.push_back(mk(5'b00000, fl(S, S, S, S, S), 1, 0, 0, 5'b00000, 0, 0));
    rows.push_back(mk(5'b00000, fl(S, S, S, S, S), 1, 0, 0, 5'b00000, 0, 1));
    rows.push_back(mk(5'b00000, fl(S, S, S, S, S), 1, 0, 0, 5'b00000, 0, 2));
    rows.push_back(mk(5'b00000, fl(S, S, S, S, S), 1, 0, 0, 5'b00000, 0, 3));
    rows.push_back(mk(5'b00000, fl(S, S, S, S, S), 0, 0, 0, 5'b00000, 0, 4));
    run_rr_rows("credit_stall", rows);
  endtask

  task automatic test_owner_stall();
    row_t rows[$];
    rows.push_back(mk(5'b01000, fl(S, S, S, H, S), 0, 0, 0, 5'b00000, 0, 4));
    rows.push_back(mk(5'b01001, fl(H, S, S, H, S), 1, 1, 3, 5'b01000, 1, 4));
    for (int k = 0; k < 3; k++)
      rows.push_back(mk(5'b00001, fl(H, S, S, B, S), 0, 0, 3, 5'b00000, 1, 4));
    rows.push_back(mk(5'b01001, fl(H, S, S, B, S), 1, 1, 3, 5'b01000, 1, 4));
    rows.push_back(mk(5'b01001, fl(H, S, S, T, S), 1, 1, 3, 5'b01000, 1, 4));
    rows.push_back(mk(5'b00001, fl(H, S, S, S, S), 0, 0, 3, 5'b00000, 0, 4));
    rows.push_back(mk(5'b00001, fl(H, S, S, S, S), 1, 1, 0, 5'b00001, 1, 4));
    rows.push_back(mk(5'b00001, fl(T, S, S, S, S), 1, 1, 0, 5'b00001, 1, 4));
    rows.push_back(mk(5'b00000, fl(S, S, S, S, S), 0, 0, 0, 5'b00000, 0, 4));
    run_rr_rows("owner_stall", rows);
  endtask

  task automatic test_hop_priority();
    row_t rows[$];
    logic [12:0] act, exp;
    bus_hop.hop_count_i = {4'd7, 4'd0, 4'd7, 4'd0, 4'd3};
    rows.push_back(mk(5'b00100, fl(S, S, S, S, S), 0, 0, 0, 5'b00000, 0, 4));
    rows.push_back(mk(5'b00100, fl(S, S, S, S, S), 1, 1, 2, 5'b00100, 1, 4));
    rows.push_back(mk(5'b10101, fl(H, S, H, S, H), 0, 0, 2, 5'b00000, 0, 4));
    rows.push_back(mk(5'b10101, fl(H, S, H, S, H), 1, 1, 4, 5'b10000, 1, 4));
    rows.push_back(mk(5'b10101, fl(H, S, H, S, T), 1, 1, 4, 5'b10000, 1, 4));
    rows.push_back(mk(5'b00101, fl(H, S, H, S, S), 0, 0, 4, 5'b00000, 0, 4));
    rows.push_back(mk(5'b00101, fl(H, S, H, S, S), 1, 1, 2, 5'b00100, 1, 4));
    rows.push_back(mk(5'b00101, fl(H, S, T, S, S), 1, 1, 2, 5'b00100, 1, 4));
    rows.push_back(mk(5'b00001, fl(H, S, S, S, S), 0, 0, 2, 5'b00000, 0, 4));
    rows.push_back(mk(5'b00001, fl(H, S, S, S, S), 1, 1, 0, 5'b00001, 1, 4));
    rows.push_back(mk(5'b00001, fl(T, S, S, S, S), 1, 1, 0, 5'b00001, 1, 4));
    rows.push_back(mk(5'b00000, fl(S, S, S, S, S), 0, 0, 0, 5'b00000, 0, 4));
    for (int k = 0; k < rows.size(); k++) begin
      apply_hop(rows[k]);
      @(negedge clk);
      act = {bus_hop.out_vld_o, bus_hop.sel_o, bus_hop.chan_alloc_o, bus_hop.busy_o, bus_hop.credit_cnt_o};
      exp = {rows[k].o_vld, rows[k].o_sel, rows[k].o_alloc, rows[k].o_busy, rows[k].o_cnt};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL hop_priority row %0d: {vld,sel,alloc,busy,cnt} got %b_%0d_%b_%b_%0d want %b_%0d_%b_%b_%0d",
                 k, act[12], act[11:9], act[8:4], act[3], act[2:0],
                 exp[12], exp[11:9], exp[8:4], exp[3], exp[2:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overflow_and_reset();
    apply_rr(mk(5'b00000, fl(S, S, S, S, S), 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    checks++;
    if (bus_rr.err_o !== 1'b0 || bus_rr.credit_cnt_o !== 3'd4) begin
      errors++;
      $display("FAIL overflow_pre: err=%b cnt=%0d want err=0 cnt=4", bus_rr.err_o, bus_rr.credit_cnt_o);
    end
    @(posedge clk); #1;
    apply_rr(mk(5'b00010, fl(S, H, S, S, S), 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    checks++;
    if (bus_rr.err_o !== 1'b1 || bus_rr.credit_cnt_o !== 3'd4) begin
      errors++;
      $display("FAIL overflow_sticky: err=%b cnt=%0d want err=1 cnt=4", bus_rr.err_o, bus_rr.credit_cnt_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus_rr.out_vld_o !== 1'b1 || bus_rr.sel_o !== 3'd1 || bus_rr.err_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_head: vld=%b sel=%0d err=%b want vld=1 sel=1 err=1",
               bus_rr.out_vld_o, bus_rr.sel_o, bus_rr.err_o);
    end
    @(posedge clk); #1;
    apply_rr(mk(5'b00010, fl(S, B, S, S, S), 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    checks++;
    if (bus_rr.out_vld_o !== 1'b1 || bus_rr.busy_o !== 1'b1 || bus_rr.credit_cnt_o !== 3'd3) begin
      errors++;
      $display("FAIL mid_packet: vld=%b busy=%b cnt=%0d want vld=1 busy=1 cnt=3",
               bus_rr.out_vld_o, bus_rr.busy_o, bus_rr.credit_cnt_o);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus_rr.out_vld_o, bus_rr.chan_alloc_o, bus_rr.busy_o, bus_rr.sel_o, bus_rr.err_o} !== 11'b0 ||
        bus_rr.credit_cnt_o !== 3'd4) begin
      errors++;
      $display("FAIL async_reset: vld=%b alloc=%b busy=%b sel=%0d err=%b cnt=%0d want zeros and cnt=4",
               bus_rr.out_vld_o, bus_rr.chan_alloc_o, bus_rr.busy_o, bus_rr.sel_o,
               bus_rr.err_o, bus_rr.credit_cnt_o);
    end
    apply_rr(mk(5'b00000, fl(S, S, S, S, S), 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus_rr.busy_o !== 1'b0 || bus_rr.credit_cnt_o !== 3'd4 || bus_rr.err_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: busy=%b cnt=%0d err=%b want busy=0 cnt=4 err=0",
               bus_rr.busy_o, bus_rr.credit_cnt_o, bus_rr.err_o);
    end
  endtask

  initial begin
    bus_rr.rtr_res_i      = '0;
    bus_rr.rtr_res_vld_i  = '1;
    bus_rr.hop_count_i    = '0;
    bus_rr.flit_id_i      = '0;
    bus_rr.data_vld_i     = '0;
    bus_rr.credit_i       = 1'b0;
    bus_hop.rtr_res_i     = '0;
    bus_hop.rtr_res_vld_i = '1;
    bus_hop.hop_count_i   = '0;
    bus_hop.flit_id_i     = '0;
    bus_hop.data_vld_i    = '0;
    bus_hop.credit_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_two_packets();
    test_route_miss();
    test_credit_stall();
    test_owner_stall();
    test_hop_priority();
    test_overflow_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1);
  end

endmodule
